// File: rtl/ls_test_seq.sv
// ----------------------------------------------------------------------------
// ls_test_seq
//   Sequencer for one shift-register upset-test run over NCH DUT chains.
//   A run walks IDLE -> PRIME -> RUN -> DRAIN -> READ -> IDLE:
//     PRIME  PRE_LEN cycles of stimulus to fill the chains, no counting
//     RUN    WIN_LEN cycles with ARM high, per-chain error counting
//     DRAIN  DRN_LEN cycles, pattern continues, counting continues so that
//            errors still in the comparator pipeline are caught
//     READ   the NCH saturating counts are handed out one per handshake
//   Every output is driven straight from a flop.
//
// Ports
//   CLK       system clock, rising edge
//   RST       asynchronous, active-high reset (aborts a run, no DONE)
//   START     single-cycle run request, ignored while busy / in DONE cycle
//   MODE      pattern select, latched on accepted START
//   WIN_LEN   RUN window length in cycles, latched on accepted START
//   ERR_IN    per-chain error strobes, counted in RUN and DRAIN only
//   DATA      stimulus bit to all chains and comparators
//   ARM       comparator enable, high during RUN only
//   BUSY      high in every state except IDLE
//   RD_VALID  readout word valid
//   RD_CH     channel index of the current readout word
//   RD_CNT    error count of channel RD_CH
//   RD_READY  host accepts the word when RD_VALID & RD_READY
//   DONE      one-cycle pulse after the last word is accepted
// ----------------------------------------------------------------------------
module ls_test_seq #(
  parameter int NCH     = 4,
  parameter int CW      = 12,
  parameter int CHW     = 2,
  parameter int PRE_LEN = 8,
  parameter int DRN_LEN = 6
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [1:0]     MODE,
  input  logic [15:0]    WIN_LEN,
  input  logic [NCH-1:0] ERR_IN,
  output logic           DATA,
  output logic           ARM,
  output logic           BUSY,
  output logic           RD_VALID,
  output logic [CHW-1:0] RD_CH,
  output logic [CW-1:0]  RD_CNT,
  input  logic           RD_READY,
  output logic           DONE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  localparam logic [CHW-1:0] LAST_CH  = CHW'(NCH - 1);
  localparam logic [15:0]    PRE_LAST = 16'(PRE_LEN - 1);
  localparam logic [15:0]    DRN_LAST = 16'(DRN_LEN - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]     state_q, state_d;
  logic [15:0]    timer_q, timer_d;    // cycles left in the current phase, minus one
  logic [1:0]     phase_q, phase_d;    // pattern phase k mod 4
  logic [1:0]     mode_q, mode_d;
  logic [15:0]    win_q, win_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [CHW-1:0] rd_ch_q, rd_ch_d;

  // Output flops
  logic           data_q, data_d;
  logic           arm_q, arm_d;
  logic           busy_q, busy_d;
  logic           rd_valid_q, rd_valid_d;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
  logic           done_q, done_d;

  logic           count_en;
  logic           active_d;

  // Stimulus bit for a given mode and phase. Checkerboard is 1 on even
  // phases, the 1,1,0,0 pattern is 1 while bit 1 of the phase is clear.
  function automatic logic pat_bit(input logic [1:0] mode, input logic [1:0] k);
    logic b;
    case (mode)
      2'b00:   b = 1'b0;
      2'b01:   b = 1'b1;
      2'b10:   b = ~k[0];
      default: b = ~k[1];
    endcase
    return b;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    timer_d  = timer_q;
    phase_d  = phase_q;
    mode_d   = mode_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    rd_ch_d  = rd_ch_q;
    done_d   = 1'b0;
    count_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A START landing in the DONE cycle belongs to the finished run.
        if (START && !done_q) begin
          state_d = S_PRIME;
          mode_d  = MODE;
          win_d   = WIN_LEN;
          timer_d = PRE_LAST;
          phase_d = 2'd0;
          rd_ch_d = '0;
          for (int i = 0; i < NCH; i++) cnt_d[i] = '0;
        end
      end

      S_PRIME: begin
        phase_d = phase_q + 2'd1;
        if (timer_q == 16'd0) begin
          if (win_q == 16'd0) begin
            state_d = S_DRAIN;
            timer_d = DRN_LAST;
          end else begin
            state_d = S_RUN;
            timer_d = win_q - 16'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      S_RUN: begin
        count_en = 1'b1;
        phase_d  = phase_q + 2'd1;
        if (timer_q == 16'd0) begin
          state_d = S_DRAIN;
          timer_d = DRN_LAST;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      S_DRAIN: begin
        count_en = 1'b1;
        phase_d  = phase_q + 2'd1;
        if (timer_q == 16'd0) begin
          state_d = S_READ;
          rd_ch_d = '0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      S_READ: begin
        if (rd_valid_q && RD_READY) begin
          if (rd_ch_q == LAST_CH) begin
            state_d = S_IDLE;
            rd_ch_d = '0;
            done_d  = 1'b1;
          end else begin
            rd_ch_d = rd_ch_q + CHW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Saturating per-chain error counters; hold at all-ones, never wrap.
    if (count_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (ERR_IN[i] && (cnt_q[i] != {CW{1'b1}})) cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output next values, derived from the next state so the flops present the
  // outputs of a state in the same cycle the state is entered.
  // --------------------------------------------------------------------------
  always_comb begin
    active_d   = (state_d == S_PRIME) || (state_d == S_RUN) || (state_d == S_DRAIN);
    data_d     = active_d ? pat_bit(mode_d, phase_d) : 1'b0;
    arm_d      = (state_d == S_RUN);
    busy_d     = (state_d != S_IDLE);
    rd_valid_d = (state_d == S_READ);
    rd_cnt_d   = rd_valid_d ? cnt_d[rd_ch_d] : '0;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      phase_q    <= '0;
      mode_q     <= '0;
      win_q      <= '0;
      rd_ch_q    <= '0;
      // NOTE: the counter array is only NCH words of flops, so it is reset
      // with everything else; an aborted run never leaks stale counts.
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      data_q     <= 1'b0;
      arm_q      <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_cnt_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // values present before the edge, independent of statement order.
      state_q    <= state_d;
      timer_q    <= timer_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      win_q      <= win_d;
      rd_ch_q    <= rd_ch_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      arm_q      <= arm_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_cnt_q   <= rd_cnt_d;
      done_q     <= done_d;
    end
  end

  assign DATA     = data_q;
  assign ARM      = arm_q;
  assign BUSY     = busy_q;
  assign RD_VALID = rd_valid_q;
  assign RD_CH    = rd_ch_q;
  assign RD_CNT   = rd_cnt_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_ls_test_seq.sv
// ----------------------------------------------------------------------------
// tb_ls_test_seq
//   Two copies of the sequencer share all inputs: one with 12-bit counters and
//   one with 4-bit counters, so saturation of the narrow counters is seen in
//   the same runs. Expected readout words are pushed to a scoreboard queue when
//   the error window has been driven and popped as the host accepts words.
// ----------------------------------------------------------------------------
module tb_ls_test_seq;

  localparam int NCH  = 4;
  localparam int CW   = 12;
  localparam int CW_S = 4;
  localparam int CHW  = 2;
  localparam int PRE  = 8;
  localparam int DRN  = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     mode;
  logic [15:0]    win_len;
  logic [NCH-1:0] err_in;
  logic           rd_ready;

  logic            data_a, arm_a, busy_a, rd_valid_a, done_a;
  logic [CHW-1:0]  rd_ch_a;
  logic [CW-1:0]   rd_cnt_a;
  logic            data_b, arm_b, busy_b, rd_valid_b, done_b;
  logic [CHW-1:0]  rd_ch_b;
  logic [CW_S-1:0] rd_cnt_b;

  ls_test_seq #(.NCH(NCH), .CW(CW), .CHW(CHW), .PRE_LEN(PRE), .DRN_LEN(DRN)) dut_a (
    .CLK(clk), .RST(rst), .START(start), .MODE(mode), .WIN_LEN(win_len),
    .ERR_IN(err_in), .DATA(data_a), .ARM(arm_a), .BUSY(busy_a),
    .RD_VALID(rd_valid_a), .RD_CH(rd_ch_a), .RD_CNT(rd_cnt_a),
    .RD_READY(rd_ready), .DONE(done_a)
  );

  ls_test_seq #(.NCH(NCH), .CW(CW_S), .CHW(CHW), .PRE_LEN(PRE), .DRN_LEN(DRN)) dut_b (
    .CLK(clk), .RST(rst), .START(start), .MODE(mode), .WIN_LEN(win_len),
    .ERR_IN(err_in), .DATA(data_b), .ARM(arm_b), .BUSY(busy_b),
    .RD_VALID(rd_valid_b), .RD_CH(rd_ch_b), .RD_CNT(rd_cnt_b),
    .RD_READY(rd_ready), .DONE(done_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int cnt_a;
    int cnt_b;
  } word_t;

  word_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    m_a[NCH];
  int    m_b[NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic pat(input logic [1:0] m, input int k);
    case (m)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return (k % 2) == 0;
      default: return (k % 4) < 2;
    endcase
  endfunction

  // Error stimulus for cycle j of a run (j=1 is the first PRIME cycle).
  function automatic logic [NCH-1:0] err_vec(input int em, input int j, input int win);
    logic [NCH-1:0] e;
    e = '0;
    case (em)
      1: begin
        e[1] = (j > PRE);
        e[2] = (j <= PRE);
      end
      2: begin
        e[0] = (j > PRE) && (j <= PRE + win);
        e[3] = 1'b1;
      end
      3: e = NCH'($urandom);
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic model_count(input logic [NCH-1:0] e);
    for (int i = 0; i < NCH; i++) begin
      if (e[i]) begin
        if (m_a[i] < (1 << CW) - 1)   m_a[i]++;
        if (m_b[i] < (1 << CW_S) - 1) m_b[i]++;
      end
    end
  endtask

  // One complete run: START, per-cycle checks through PRIME/RUN/DRAIN,
  // scoreboarded readout with an optional stall, DONE pulse.
  task automatic do_run(input logic [1:0] m, input int win, input int em,
                        input int stall_ch, input int stall_len, input bit start_in_read);
    int n;
    int stalls;
    int cyc;
    logic [NCH-1:0] e;
    n = PRE + win + DRN;
    for (int i = 0; i < NCH; i++) begin
      m_a[i] = 0;
      m_b[i] = 0;
    end

    @(negedge clk);
    start   = 1'b1;
    mode    = m;
    win_len = 16'(win);
    err_in  = NCH'($urandom);           // IDLE: must not count
    @(negedge clk);
    start   = 1'b0;
    mode    = ~m;                       // late changes must have no effect
    win_len = 16'(win + 7);

    for (int j = 1; j <= n; j++) begin
      if (j > 1) @(negedge clk);
      check("data", data_a, pat(m, j - 1));
      check("data_b", data_b, pat(m, j - 1));
      check("arm", arm_a, (j > PRE) && (j <= PRE + win));
      check("busy", busy_a, 1);
      check("rd_valid_run", rd_valid_a, 0);
      start = (j == 3);                 // dropped while busy
      e = err_vec(em, j, win);
      err_in = e;
      if (j > PRE) model_count(e);
    end

    for (int i = 0; i < NCH; i++) sb.push_back('{i, m_a[i], m_b[i]});

    stalls = 0;
    cyc    = 0;
    while (sb.size() > 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      err_in = NCH'($urandom);          // READ: must not count
      start  = start_in_read && (cyc == 2);
      check("rd_valid", rd_valid_a, 1);
      check("rd_valid_b", rd_valid_b, 1);
      check("busy_read", busy_a, 1);
      check("data_read", data_a, 0);
      check("arm_read", arm_a, 0);
      check("rd_ch", rd_ch_a, sb[0].ch);
      check("rd_ch_b", rd_ch_b, sb[0].ch);
      check("rd_cnt", rd_cnt_a, sb[0].cnt_a);
      check("rd_cnt_b", rd_cnt_b, sb[0].cnt_b);
      if (sb[0].ch == stall_ch && stalls < stall_len) begin
        rd_ready = 1'b0;
        stalls++;
      end else begin
        rd_ready = 1'b1;
        void'(sb.pop_front());
      end
    end
    check("read_left", sb.size(), 0);
    check("read_cycles", cyc, NCH + stall_len);

    @(negedge clk);
    rd_ready = 1'b0;
    start    = 1'b1;                    // START in the DONE cycle is ignored
    check("done", done_a, 1);
    check("done_b", done_b, 1);
    check("busy_done", busy_a, 0);
    check("rd_valid_done", rd_valid_a, 0);
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done_a, 0);
    check("busy_idle", busy_a, 0);
    check("data_idle", data_a, 0);
  endtask

  // Run aborted by RST in the middle of RUN.
  task automatic do_abort();
    @(negedge clk);
    start   = 1'b1;
    mode    = 2'b01;
    win_len = 16'd30;
    @(negedge clk);
    start  = 1'b0;
    err_in = '1;
    for (int j = 2; j <= PRE + 5; j++) @(negedge clk);
    check("arm_before_abort", arm_a, 1);
    rst = 1'b1;
    #1;
    check("abort_data", data_a, 0);
    check("abort_arm", arm_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_rd_valid", rd_valid_a, 0);
    check("abort_rd_ch", rd_ch_a, 0);
    check("abort_rd_cnt", rd_cnt_a, 0);
    check("abort_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("abort_no_done", done_a, 0);
      check("abort_idle", busy_a, 0);
    end
    err_in = '0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 2'b00;
    win_len  = 16'd0;
    err_in   = '0;
    rd_ready = 1'b0;
    #1;
    check("rst_data", data_a, 0);
    check("rst_arm", arm_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_rd_valid", rd_valid_a, 0);
    check("rst_rd_ch", rd_ch_a, 0);
    check("rst_rd_cnt", rd_cnt_a, 0);
    check("rst_done", done_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_run(2'b10, 20, 0, -1, 0, 1'b0);   // checkerboard, no errors
    do_run(2'b01, 10, 1, -1, 0, 1'b0);   // ch1 16, ch2 only in PRIME
    do_run(2'b11, 40, 2, 2, 5, 1'b0);    // narrow counters saturate, ch2 stall
    do_run(2'b11, 0, 3, -1, 0, 1'b1);    // RUN skipped, START in READ
    do_abort();
    do_run(2'b10, 5, 3, 1, 2, 1'b0);     // counts restart from zero
    do_run(2'b00, 4100, 2, 3, 1, 1'b0);  // wide counters saturate

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
